// File: rtl/la_cmd_pkg.sv
// Shared types and constants for the logic-analyzer command processor:
// opcodes, FSM states, register addresses and the ACK/NAK response bytes.
package la_cmd_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_DUMP  = 2'b10,
        OP_NAK   = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESP,
        ST_WAIT_SENT,
        ST_DUMP_RD,
        ST_DUMP_SEND,
        ST_DUMP_WAIT
    } state_e;

    localparam logic [5:0] REG_TRIGCFG  = 6'h00;
    localparam logic [5:0] REG_DECIM    = 6'h10;
    localparam logic [5:0] REG_VIH      = 6'h11;
    localparam logic [5:0] REG_VIL      = 6'h12;
    localparam logic [5:0] REG_MATCHH   = 6'h13;
    localparam logic [5:0] REG_MATCHL   = 6'h14;
    localparam logic [5:0] REG_MASKH    = 6'h15;
    localparam logic [5:0] REG_MASKL    = 6'h16;
    localparam logic [5:0] REG_BAUDH    = 6'h17;
    localparam logic [5:0] REG_BAUDL    = 6'h18;
    localparam logic [5:0] REG_TRIGPOSH = 6'h19;
    localparam logic [5:0] REG_TRIGPOSL = 6'h1A;

    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'hEE;

endpackage

// File: rtl/la_cmd_if.sv
// Host-link handshake between the UART wrapper (master) and the
// command processor (slave).
interface la_cmd_if;

    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        resp_sent;
    logic [7:0]  resp;
    logic        send_resp;
    logic        clr_cmd_rdy;

    modport master (
        output cmd, cmd_rdy, resp_sent,
        input  resp, send_resp, clr_cmd_rdy
    );

    modport slave (
        input  cmd, cmd_rdy, resp_sent,
        output resp, send_resp, clr_cmd_rdy
    );

endinterface

// File: rtl/la_cfg_regfile.sv
// Capture configuration registers: host write port, zero-extending read mux
// and the capture_done sticky bit in TrigCfg[5].
module la_cfg_regfile
    import la_cmd_pkg::*;
#(
    parameter int NUM_CH = 5,
    parameter int LOG2   = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_we,
    input  logic [5:0]          i_addr,
    input  logic [7:0]          i_wdata,
    input  logic                i_set_capture_done,
    output logic                o_hit,
    output logic [7:0]          o_rdata,
    output logic [5:0]          o_trig_cfg,
    output logic [NUM_CH*5-1:0] o_ch_trig_cfg,
    output logic [3:0]          o_decimator,
    output logic [7:0]          o_vih,
    output logic [7:0]          o_vil,
    output logic [7:0]          o_match_h,
    output logic [7:0]          o_match_l,
    output logic [7:0]          o_mask_h,
    output logic [7:0]          o_mask_l,
    output logic [7:0]          o_baud_h,
    output logic [7:0]          o_baud_l,
    output logic [LOG2-1:0]     o_trig_pos
);

    logic [5:0]      r_trig_cfg;
    logic [4:0]      r_ch_trig [NUM_CH];
    logic [3:0]      r_decim;
    logic [7:0]      r_vih, r_vil, r_match_h, r_match_l, r_mask_h, r_mask_l;
    logic [7:0]      r_baud_h, r_baud_l;
    logic [LOG2-1:0] r_trig_pos;
    logic [7:0]      w_trig_pos_h;

    always_comb begin
        w_trig_pos_h = '0;
        w_trig_pos_h[LOG2-9:0] = r_trig_pos[LOG2-1:8];
    end

    always_comb begin
        o_hit   = 1'b1;
        o_rdata = '0;
        case (i_addr)
            REG_TRIGCFG:  o_rdata = {2'b00, r_trig_cfg};
            REG_DECIM:    o_rdata = {4'h0, r_decim};
            REG_VIH:      o_rdata = r_vih;
            REG_VIL:      o_rdata = r_vil;
            REG_MATCHH:   o_rdata = r_match_h;
            REG_MATCHL:   o_rdata = r_match_l;
            REG_MASKH:    o_rdata = r_mask_h;
            REG_MASKL:    o_rdata = r_mask_l;
            REG_BAUDH:    o_rdata = r_baud_h;
            REG_BAUDL:    o_rdata = r_baud_l;
            REG_TRIGPOSH: o_rdata = w_trig_pos_h;
            REG_TRIGPOSL: o_rdata = r_trig_pos[7:0];
            default:      o_hit   = 1'b0;
        endcase
        // Per-channel trigger registers occupy 0x01..NUM_CH.
        for (int n = 0; n < NUM_CH; n++) begin
            if (int'(i_addr) == n + 1) begin
                o_hit   = 1'b1;
                o_rdata = {3'b000, r_ch_trig[n]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trig_cfg <= 6'h03;
            for (int n = 0; n < NUM_CH; n++) r_ch_trig[n] <= 5'h01;
            r_decim    <= '0;
            r_vih      <= 8'hAA;
            r_vil      <= 8'h55;
            r_match_h  <= '0;
            r_match_l  <= '0;
            r_mask_h   <= '0;
            r_mask_l   <= '0;
            r_baud_h   <= 8'h03;
            r_baud_l   <= 8'h64;
            r_trig_pos <= LOG2'(1);
        end else begin
            // A host write to TrigCfg in the same cycle overrides capture_done.
            if (i_set_capture_done && !(i_we && i_addr == REG_TRIGCFG))
                r_trig_cfg[5] <= 1'b1;
            if (i_we) begin
                for (int n = 0; n < NUM_CH; n++)
                    if (int'(i_addr) == n + 1) r_ch_trig[n] <= i_wdata[4:0];
                case (i_addr)
                    REG_TRIGCFG:  r_trig_cfg <= i_wdata[5:0];
                    REG_DECIM:    r_decim    <= i_wdata[3:0];
                    REG_VIH:      r_vih      <= i_wdata;
                    REG_VIL:      r_vil      <= i_wdata;
                    REG_MATCHH:   r_match_h  <= i_wdata;
                    REG_MATCHL:   r_match_l  <= i_wdata;
                    REG_MASKH:    r_mask_h   <= i_wdata;
                    REG_MASKL:    r_mask_l   <= i_wdata;
                    REG_BAUDH:    r_baud_h   <= i_wdata;
                    REG_BAUDL:    r_baud_l   <= i_wdata;
                    REG_TRIGPOSH: r_trig_pos[LOG2-1:8] <= i_wdata[LOG2-9:0];
                    REG_TRIGPOSL: r_trig_pos[7:0]      <= i_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        for (int n = 0; n < NUM_CH; n++) o_ch_trig_cfg[n*5 +: 5] = r_ch_trig[n];
    end

    assign o_trig_cfg  = r_trig_cfg;
    assign o_decimator = r_decim;
    assign o_vih       = r_vih;
    assign o_vil       = r_vil;
    assign o_match_h   = r_match_h;
    assign o_match_l   = r_match_l;
    assign o_mask_h    = r_mask_h;
    assign o_mask_l    = r_mask_l;
    assign o_baud_h    = r_baud_h;
    assign o_baud_l    = r_baud_l;
    assign o_trig_pos  = r_trig_pos;

endmodule

// File: rtl/la_cmd_proc.sv
// Host command processor: decodes UART commands, accesses the config
// register file and streams a channel's circular sample RAM back to the host.
module la_cmd_proc
    import la_cmd_pkg::*;
#(
    parameter int NUM_CH  = 5,
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    la_cmd_if.slave             host,
    input  logic                set_capture_done,
    input  logic [LOG2-1:0]     ram_addr,
    input  logic [NUM_CH*8-1:0] rdata,
    output logic [LOG2-1:0]     addr_ptr,
    output logic [5:0]          TrigCfg,
    output logic [NUM_CH*5-1:0] CHTrigCfg,
    output logic [3:0]          decimator,
    output logic [7:0]          VIH,
    output logic [7:0]          VIL,
    output logic [7:0]          matchH,
    output logic [7:0]          matchL,
    output logic [7:0]          maskH,
    output logic [7:0]          maskL,
    output logic [7:0]          baud_cntH,
    output logic [7:0]          baud_cntL,
    output logic [LOG2-1:0]     trig_pos
);

    localparam logic [LOG2:0]   LAST_CNT  = (LOG2+1)'(ENTRIES);
    localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);

    state_e          r_state, w_state_nxt;
    logic [7:0]      r_resp, w_resp_nxt;
    logic            r_send_resp, w_send_nxt;
    logic            r_clr_cmd_rdy, w_clr_nxt;
    logic [LOG2-1:0] r_addr_ptr, w_addr_nxt;
    logic [LOG2:0]   r_cnt, w_cnt_nxt;
    logic [2:0]      r_ch, w_ch_nxt;

    opcode_e    w_opcode;
    logic       w_start, w_we, w_hit;
    logic [7:0] w_rd_byte, w_dump_byte;

    assign w_opcode = opcode_e'(host.cmd[15:14]);
    // The extra term keeps a cmd_rdy that the UART has not yet dropped from re-firing.
    assign w_start  = host.cmd_rdy && !r_clr_cmd_rdy;
    assign w_we     = (r_state == ST_IDLE) && w_start && (w_opcode == OP_WRITE) && w_hit;

    always_comb begin
        w_dump_byte = '0;
        for (int n = 0; n < NUM_CH; n++)
            if (r_ch == 3'(n)) w_dump_byte = rdata[n*8 +: 8];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_resp_nxt  = r_resp;
        w_send_nxt  = 1'b0;
        w_clr_nxt   = 1'b0;
        w_addr_nxt  = r_addr_ptr;
        w_cnt_nxt   = r_cnt;
        w_ch_nxt    = r_ch;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_RESP;
                    case (w_opcode)
                        OP_READ:  w_resp_nxt = w_hit ? w_rd_byte : NAK;
                        OP_WRITE: w_resp_nxt = w_hit ? ACK : NAK;
                        OP_DUMP: begin
                            if (int'(host.cmd[10:8]) < NUM_CH) begin
                                w_ch_nxt    = host.cmd[10:8];
                                w_addr_nxt  = ram_addr;
                                w_cnt_nxt   = '0;
                                w_state_nxt = ST_DUMP_RD;
                            end else begin
                                w_resp_nxt = NAK;
                            end
                        end
                        default:  w_resp_nxt = NAK;
                    endcase
                end
            end
            ST_RESP: begin
                w_send_nxt  = 1'b1;
                w_state_nxt = ST_WAIT_SENT;
            end
            ST_WAIT_SENT: begin
                if (host.resp_sent) begin
                    w_clr_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DUMP_RD: w_state_nxt = ST_DUMP_SEND;
            ST_DUMP_SEND: begin
                w_resp_nxt  = w_dump_byte;
                w_send_nxt  = 1'b1;
                w_cnt_nxt   = r_cnt + 1'b1;
                w_state_nxt = ST_DUMP_WAIT;
            end
            ST_DUMP_WAIT: begin
                if (host.resp_sent) begin
                    if (r_cnt == LAST_CNT) begin
                        w_clr_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_addr_nxt  = (r_addr_ptr == LAST_ADDR) ? '0 : r_addr_ptr + 1'b1;
                        w_state_nxt = ST_DUMP_RD;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_resp        <= '0;
            r_send_resp   <= 1'b0;
            r_clr_cmd_rdy <= 1'b0;
            r_addr_ptr    <= '0;
            r_cnt         <= '0;
            r_ch          <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_resp        <= w_resp_nxt;
            r_send_resp   <= w_send_nxt;
            r_clr_cmd_rdy <= w_clr_nxt;
            r_addr_ptr    <= w_addr_nxt;
            r_cnt         <= w_cnt_nxt;
            r_ch          <= w_ch_nxt;
        end
    end

    assign host.resp        = r_resp;
    assign host.send_resp   = r_send_resp;
    assign host.clr_cmd_rdy = r_clr_cmd_rdy;
    assign addr_ptr         = r_addr_ptr;

    la_cfg_regfile #(
        .NUM_CH (NUM_CH),
        .LOG2   (LOG2)
    ) u_regfile (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_we               (w_we),
        .i_addr             (host.cmd[13:8]),
        .i_wdata            (host.cmd[7:0]),
        .i_set_capture_done (set_capture_done),
        .o_hit              (w_hit),
        .o_rdata            (w_rd_byte),
        .o_trig_cfg         (TrigCfg),
        .o_ch_trig_cfg      (CHTrigCfg),
        .o_decimator        (decimator),
        .o_vih              (VIH),
        .o_vil              (VIL),
        .o_match_h          (matchH),
        .o_match_l          (matchL),
        .o_mask_h           (maskH),
        .o_mask_l           (maskL),
        .o_baud_h           (baud_cntH),
        .o_baud_l           (baud_cntL),
        .o_trig_pos         (trig_pos)
    );

endmodule

// File: tb/tb_la_cmd_proc.sv
// Randomized self-checking bench for la_cmd_proc: a UART/RAM model drives the
// host link and every response is compared with a register-map reference model.
module tb_la_cmd_proc;

    localparam int NUM_CH       = 5;
    localparam int ENTRIES      = 384;
    localparam int LOG2         = 9;
    localparam int CYCLE_BUDGET = 6000;

    logic                clk;
    logic                rst_n;
    logic                set_capture_done;
    logic [LOG2-1:0]     ram_addr;
    logic [NUM_CH*8-1:0] rdata;
    logic [LOG2-1:0]     addr_ptr;
    logic [5:0]          TrigCfg;
    logic [NUM_CH*5-1:0] CHTrigCfg;
    logic [3:0]          decimator;
    logic [7:0]          VIH, VIL, matchH, matchL, maskH, maskL, baud_cntH, baud_cntL;
    logic [LOG2-1:0]     trig_pos;

    la_cmd_if u_if ();

    la_cmd_proc #(
        .NUM_CH  (NUM_CH),
        .ENTRIES (ENTRIES),
        .LOG2    (LOG2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .host             (u_if.slave),
        .set_capture_done (set_capture_done),
        .ram_addr         (ram_addr),
        .rdata            (rdata),
        .addr_ptr         (addr_ptr),
        .TrigCfg          (TrigCfg),
        .CHTrigCfg        (CHTrigCfg),
        .decimator        (decimator),
        .VIH              (VIH),
        .VIL              (VIL),
        .matchH           (matchH),
        .matchL           (matchL),
        .maskH            (maskH),
        .maskL            (maskL),
        .baud_cntH        (baud_cntH),
        .baud_cntL        (baud_cntL),
        .trig_pos         (trig_pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample RAMs with a synchronous read on the shared address.
    logic [7:0] mem [NUM_CH][ENTRIES];
    always @(posedge clk) begin
        for (int n = 0; n < NUM_CH; n++) rdata[n*8 +: 8] <= mem[n][addr_ptr];
    end

    // Reference model: one byte per register address, masked to the register width.
    logic [7:0] mdl   [64];
    logic [7:0] wmask [64];
    bit         legal [64];
    logic [7:0] legalList [$];
    logic [7:0] expBytes [$];
    int         expLat;

    logic [7:0] rxBytes [$];
    int  clrCount, firstLat, extraSend;
    bit  stableErr, rangeErr, timedOut, aborted;
    int  nPass, nChecks;

    function automatic void modelInit();
        for (int a = 0; a < 64; a++) begin
            legal[a] = 1'b0;
            wmask[a] = 8'hFF;
        end
        legal[0] = 1'b1; wmask[0] = 8'h3F;
        for (int n = 1; n <= NUM_CH; n++) begin
            legal[n] = 1'b1; wmask[n] = 8'h1F;
        end
        for (int a = 16; a <= 26; a++) legal[a] = 1'b1;
        wmask[16] = 8'h0F;
        wmask[25] = 8'((1 << (LOG2 - 8)) - 1);
        legalList.delete();
        for (int a = 0; a < 64; a++) if (legal[a]) legalList.push_back(8'(a));
    endfunction

    function automatic void modelReset();
        for (int a = 0; a < 64; a++) mdl[a] = 8'h00;
        mdl[0] = 8'h03;
        for (int n = 1; n <= NUM_CH; n++) mdl[n] = 8'h01;
        mdl[17] = 8'hAA;
        mdl[18] = 8'h55;
        mdl[23] = 8'h03;
        mdl[24] = 8'h64;
        mdl[25] = 8'h00;
        mdl[26] = 8'h01;
    endfunction

    function automatic void predict(input logic [15:0] c, input int start);
        int a;
        int ch;
        a  = int'(c[13:8]);
        ch = int'(c[10:8]);
        expBytes.delete();
        expLat = 2;
        case (c[15:14])
            2'b00: expBytes.push_back(legal[a] ? mdl[a] : 8'hEE);
            2'b01: begin
                if (legal[a]) begin
                    mdl[a] = c[7:0] & wmask[a];
                    expBytes.push_back(8'hA5);
                end else begin
                    expBytes.push_back(8'hEE);
                end
            end
            2'b10: begin
                if (ch < NUM_CH) begin
                    expLat = 3;
                    for (int i = 0; i < ENTRIES; i++)
                        expBytes.push_back(mem[ch][(start + i) % ENTRIES]);
                end else begin
                    expBytes.push_back(8'hEE);
                end
            end
            default: expBytes.push_back(8'hEE);
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else
            nPass++;
    endtask

    task automatic checkConfig(input string tag);
        logic [15:0] tp;
        tp = {mdl[25], mdl[26]};
        checkOutput({tag, "_TrigCfg"}, 32'(TrigCfg), 32'(mdl[0][5:0]));
        for (int n = 0; n < NUM_CH; n++)
            checkOutput({tag, "_CHTrigCfg"}, 32'(CHTrigCfg[n*5 +: 5]), 32'(mdl[n+1][4:0]));
        checkOutput({tag, "_decimator"}, 32'(decimator), 32'(mdl[16][3:0]));
        checkOutput({tag, "_VIH"},       32'(VIH),       32'(mdl[17]));
        checkOutput({tag, "_VIL"},       32'(VIL),       32'(mdl[18]));
        checkOutput({tag, "_matchH"},    32'(matchH),    32'(mdl[19]));
        checkOutput({tag, "_matchL"},    32'(matchL),    32'(mdl[20]));
        checkOutput({tag, "_maskH"},     32'(maskH),     32'(mdl[21]));
        checkOutput({tag, "_maskL"},     32'(maskL),     32'(mdl[22]));
        checkOutput({tag, "_baudH"},     32'(baud_cntH), 32'(mdl[23]));
        checkOutput({tag, "_baudL"},     32'(baud_cntL), 32'(mdl[24]));
        checkOutput({tag, "_trig_pos"},  32'(trig_pos),  32'(tp[LOG2-1:0]));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_resp"},        32'(u_if.resp),        32'h00);
        checkOutput({tag, "_send_resp"},   32'(u_if.send_resp),   32'h0);
        checkOutput({tag, "_clr_cmd_rdy"}, 32'(u_if.clr_cmd_rdy), 32'h0);
        checkOutput({tag, "_addr_ptr"},    32'(addr_ptr),         32'h0);
        checkConfig(tag);
    endtask

    // Plays the UART side of one command; optionally asserts reset after abortAfter bytes.
    task automatic applyStimulus(input logic [15:0] c, input bit capPulse, input int abortAfter);
        int cyc;
        int pending;
        bit done;
        bit seen;
        logic [7:0] lastResp;
        rxBytes.delete();
        clrCount = 0; firstLat = -1; extraSend = 0;
        stableErr = 0; rangeErr = 0; timedOut = 0; aborted = 0;
        cyc = 0; pending = 0; done = 0; seen = 0; lastResp = '0;
        @(negedge clk);
        u_if.cmd = c;
        u_if.cmd_rdy = 1'b1;
        set_capture_done = capPulse;
        while (!done && cyc < CYCLE_BUDGET) begin
            @(negedge clk);
            cyc++;
            set_capture_done = 1'b0;
            u_if.resp_sent = 1'b0;
            if (int'(addr_ptr) >= ENTRIES) rangeErr = 1;
            if (u_if.clr_cmd_rdy) begin
                clrCount++;
                u_if.cmd_rdy = 1'b0;
                done = 1;
            end else if (u_if.send_resp) begin
                rxBytes.push_back(u_if.resp);
                lastResp = u_if.resp;
                seen = 1;
                if (firstLat < 0) firstLat = cyc;
                if (rxBytes.size() == 1) ram_addr = LOG2'($urandom_range(0, ENTRIES - 1));
                if (abortAfter > 0 && rxBytes.size() == abortAfter) begin
                    rst_n = 1'b0;
                    u_if.cmd_rdy = 1'b0;
                    aborted = 1;
                    done = 1;
                end else begin
                    pending = $urandom_range(1, 3);
                end
            end else begin
                if (seen && u_if.resp !== lastResp) stableErr = 1;
                if (pending > 0) begin
                    pending--;
                    if (pending == 0) u_if.resp_sent = 1'b1;
                end
            end
        end
        if (!done) timedOut = 1;
        u_if.cmd_rdy = 1'b0;
        u_if.resp_sent = 1'b0;
        if (!aborted) begin
            repeat (3) begin
                @(negedge clk);
                if (u_if.clr_cmd_rdy) clrCount++;
                if (u_if.send_resp) extraSend++;
            end
        end
    endtask

    task automatic runAndCheck(input string tag, input logic [15:0] c, input bit capPulse);
        predict(c, int'(ram_addr));
        if (capPulse && !(c[15:14] == 2'b01 && c[13:8] == 6'h00)) mdl[0] = mdl[0] | 8'h20;
        applyStimulus(c, capPulse, 0);
        checkOutput({tag, "_timeout"}, 32'(timedOut), 32'h0);
        checkOutput({tag, "_count"}, 32'(rxBytes.size()), 32'(expBytes.size()));
        for (int i = 0; i < rxBytes.size() && i < expBytes.size(); i++)
            checkOutput({tag, "_byte"}, 32'(rxBytes[i]), 32'(expBytes[i]));
        checkOutput({tag, "_latency"}, 32'(firstLat), 32'(expLat));
        checkOutput({tag, "_clr_once"}, 32'(clrCount), 32'h1);
        checkOutput({tag, "_extra_send"}, 32'(extraSend), 32'h0);
        checkOutput({tag, "_resp_stable"}, 32'(stableErr), 32'h0);
        checkOutput({tag, "_addr_range"}, 32'(rangeErr), 32'h0);
    endtask

    initial begin
        int sends;
        logic [1:0]  op;
        logic [5:0]  a;
        logic [15:0] c;
        nPass = 0; nChecks = 0;
        rst_n = 1'b1;
        u_if.cmd = '0; u_if.cmd_rdy = 1'b0; u_if.resp_sent = 1'b0;
        set_capture_done = 1'b0;
        ram_addr = '0;
        for (int n = 0; n < NUM_CH; n++)
            for (int k = 0; k < ENTRIES; k++) mem[n][k] = 8'($urandom);
        modelInit();
        modelReset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkReset("por");

        runAndCheck("wr_maskH", 16'h55AF, 1'b0);
        runAndCheck("rd_maskH", 16'h1500, 1'b0);
        runAndCheck("rd_bad_addr", 16'h3F00, 1'b0);
        runAndCheck("op_nak", 16'hC000, 1'b0);
        runAndCheck("dump_bad_ch", 16'h8700, 1'b0);
        checkConfig("directed");

        // resp_sent while idle must be ignored.
        sends = 0;
        @(negedge clk) u_if.resp_sent = 1'b1;
        @(negedge clk) u_if.resp_sent = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (u_if.send_resp || u_if.clr_cmd_rdy) sends++;
        end
        checkOutput("idle_resp_sent", 32'(sends), 32'h0);

        @(negedge clk) set_capture_done = 1'b1;
        @(negedge clk) set_capture_done = 1'b0;
        mdl[0] = mdl[0] | 8'h20;
        runAndCheck("rd_capture_done", 16'h0000, 1'b0);
        runAndCheck("wr_trig_vs_capture", 16'h4001, 1'b1);
        runAndCheck("rd_trig_after", 16'h0000, 1'b0);

        for (int k = 0; k < ENTRIES; k++) mem[0][k] = 8'(k + 1);
        ram_addr = '0;
        runAndCheck("dump_ch0", 16'h8000, 1'b0);

        for (int k = 0; k < ENTRIES; k++) mem[2][k] = 8'(k);
        ram_addr = LOG2'(380);
        runAndCheck("dump_wrap", 16'h8200, 1'b0);

        ram_addr = LOG2'($urandom_range(0, ENTRIES - 1));
        runAndCheck("dump_rand", {8'h84, 8'($urandom)}, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 2));
            if (op == 2'd2) op = 2'd3;
            if ($urandom_range(0, 1) == 1)
                a = 6'(legalList[$urandom_range(0, legalList.size() - 1)]);
            else
                a = 6'($urandom_range(0, 63));
            c = {op, a, 8'($urandom)};
            runAndCheck("rand_cmd", c, $urandom_range(0, 3) == 0);
            checkConfig("rand_cfg");
        end

        // Reset in the middle of a dump.
        ram_addr = LOG2'($urandom_range(0, ENTRIES - 1));
        applyStimulus(16'h8100, 1'b0, 10);
        checkOutput("abort_bytes", 32'(rxBytes.size()), 32'd10);
        modelReset();
        sends = 0;
        repeat (3) begin
            @(negedge clk);
            if (u_if.send_resp) sends++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (u_if.send_resp) sends++;
        end
        checkOutput("abort_no_send", 32'(sends), 32'h0);
        checkReset("abort");
        runAndCheck("rd_vih_after_abort", 16'h1100, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
